// File: rtl/mem_stage_if.sv
// mem_stage port bundle: EX/MEM inputs, redirect outputs,
// MEM/WB register outputs and fault recorder outputs.
interface mem_stage_if;
  logic [29:0] Btarg;
  logic [29:0] Jtarg;
  logic        Zero;
  logic        Overflow;
  logic [31:0] Addr;
  logic [31:0] Di;
  logic [4:0]  Rw;
  logic        MemWr;
  logic        Branch;
  logic        Jump;
  logic        MemtoReg;
  logic        RegWr;
  logic [1:0]  PCsrc;
  logic [29:0] PCtarg;
  logic        Flush;
  logic [31:0] Do_out;
  logic [31:0] ALUout_out;
  logic [4:0]  Rw_out;
  logic        MemtoReg_out;
  logic        RegWr_out;
  logic        Fault;
  logic [1:0]  FaultCause;
  logic [31:0] FaultAddr;

  modport master (
    output Btarg, Jtarg, Zero, Overflow,
    output Addr, Di, Rw,
    output MemWr, Branch, Jump, MemtoReg, RegWr,
    input  PCsrc, PCtarg, Flush,
    input  Do_out, ALUout_out, Rw_out,
    input  MemtoReg_out, RegWr_out,
    input  Fault, FaultCause, FaultAddr
  );

  modport slave (
    input  Btarg, Jtarg, Zero, Overflow,
    input  Addr, Di, Rw,
    input  MemWr, Branch, Jump, MemtoReg, RegWr,
    output PCsrc, PCtarg, Flush,
    output Do_out, ALUout_out, Rw_out,
    output MemtoReg_out, RegWr_out,
    output Fault, FaultCause, FaultAddr
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: data memory, redirect resolution,
// MEM/WB register and sticky fault recorder (falling edge).
module mem_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic mis;
  logic kill;
  logic taken;
  logic we;

  always_comb begin
    idx   = bus.Addr[AW+1:2];
    mis   = (bus.MemWr | bus.MemtoReg)
          & (bus.Addr[1:0] != 2'b00);
    kill  = mis | bus.Overflow;
    taken = bus.Branch & bus.Zero & ~bus.Overflow;
    we    = bus.MemWr & ~kill & ~rst;
  end

  // Jump wins over a simultaneously taken branch.
  always_comb begin
    bus.PCsrc  = 2'b00;
    bus.PCtarg = bus.Btarg;
    if (bus.Jump) begin
      bus.PCsrc  = 2'b10;
      bus.PCtarg = bus.Jtarg;
    end else if (taken) begin
      bus.PCsrc  = 2'b01;
    end
    bus.Flush = (bus.PCsrc != 2'b00);
  end

  always_ff @(negedge clk) begin
    if (we) begin
      mem[idx] <= bus.Di;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      bus.Do_out       <= '0;
      bus.ALUout_out   <= '0;
      bus.Rw_out       <= '0;
      bus.MemtoReg_out <= 1'b0;
      bus.RegWr_out    <= 1'b0;
    end else begin
      bus.Do_out       <= mem[idx];
      bus.ALUout_out   <= bus.Addr;
      bus.Rw_out       <= bus.Rw;
      bus.MemtoReg_out <= bus.MemtoReg & ~kill;
      bus.RegWr_out    <= bus.RegWr & ~kill;
    end
  end

  // Only the first fault since reset is kept.
  always_ff @(negedge clk) begin
    if (rst) begin
      bus.Fault      <= 1'b0;
      bus.FaultCause <= 2'b00;
      bus.FaultAddr  <= '0;
    end else if (kill && !bus.Fault) begin
      bus.Fault      <= 1'b1;
      bus.FaultCause <= mis ? 2'b01 : 2'b10;
      bus.FaultAddr  <= bus.Addr;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed plan items
// followed by random traffic against a word-array model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.DEPTH(1024), .AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    bit          rst;
    logic [29:0] btarg;
    logic [29:0] jtarg;
    bit          zero;
    bit          ovf;
    logic [31:0] addr;
    logic [31:0] di;
    logic [4:0]  rw;
    bit          memwr;
    bit          branch;
    bit          jump;
    bit          m2r;
    bit          regwr;
  } stim_t;

  typedef struct {
    logic [1:0]  pcsrc;
    logic [29:0] pctarg;
    bit          flush;
    logic [31:0] dout;
    bit          do_chk;
    logic [31:0] alu;
    logic [4:0]  rw;
    bit          m2r;
    bit          regwr;
    bit          fault;
    logic [1:0]  cause;
    logic [31:0] faddr;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl [1024];
  bit          known [1024];
  bit          m_fault = 0;
  logic [1:0]  m_cause = 0;
  logic [31:0] m_faddr = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, req, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit mis, kill, taken;
    int i;
    @(posedge clk);
    #1;
    rst          = s.rst;
    bus.Btarg    = s.btarg;
    bus.Jtarg    = s.jtarg;
    bus.Zero     = s.zero;
    bus.Overflow = s.ovf;
    bus.Addr     = s.addr;
    bus.Di       = s.di;
    bus.Rw       = s.rw;
    bus.MemWr    = s.memwr;
    bus.Branch   = s.branch;
    bus.Jump     = s.jump;
    bus.MemtoReg = s.m2r;
    bus.RegWr    = s.regwr;
    mis   = (s.memwr || s.m2r) && (s.addr % 4 != 0);
    kill  = mis || s.ovf;
    taken = s.branch && s.zero && !s.ovf;
    e.pcsrc  = s.jump ? 2'd2 : (taken ? 2'd1 : 2'd0);
    e.pctarg = s.jump ? s.jtarg : s.btarg;
    e.flush  = (e.pcsrc != 0);
    i = int'((s.addr / 4) % 1024);
    if (s.rst) begin
      e.dout = 0; e.do_chk = 1;
      e.alu = 0; e.rw = 0; e.m2r = 0; e.regwr = 0;
      m_fault = 0; m_cause = 0; m_faddr = 0;
    end else begin
      e.dout   = mdl[i];
      e.do_chk = known[i];
      if (s.memwr && !kill) begin
        mdl[i]   = s.di;
        known[i] = 1;
      end
      e.alu   = s.addr;
      e.rw    = s.rw;
      e.m2r   = s.m2r && !kill;
      e.regwr = s.regwr && !kill;
      if (kill && !m_fault) begin
        m_fault = 1;
        m_cause = mis ? 2'd1 : 2'd2;
        m_faddr = s.addr;
      end
    end
    e.fault = m_fault;
    e.cause = m_cause;
    e.faddr = m_faddr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [1:0]  pc;
    logic [29:0] pt;
    logic        fl;
    forever begin
      @(negedge clk);
      pc = bus.PCsrc;
      pt = bus.PCtarg;
      fl = bus.Flush;
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("PCsrc", 32'(pc), 32'(e.pcsrc));
        check("PCtarg", 32'(pt), 32'(e.pctarg));
        check("Flush", 32'(fl), 32'(e.flush));
        if (e.do_chk)
          check("Do_out", bus.Do_out, e.dout);
        check("ALUout_out", bus.ALUout_out, e.alu);
        check("Rw_out", 32'(bus.Rw_out), 32'(e.rw));
        check("MemtoReg_out", 32'(bus.MemtoReg_out),
              32'(e.m2r));
        check("RegWr_out", 32'(bus.RegWr_out),
              32'(e.regwr));
        check("Fault", 32'(bus.Fault), 32'(e.fault));
        check("FaultCause", 32'(bus.FaultCause),
              32'(e.cause));
        check("FaultAddr", bus.FaultAddr, e.faddr);
      end
    end
  end

  initial begin : driver
    stim_t s;
    int budget;
    for (int k = 0; k < 1024; k++) known[k] = 0;
    rst = 1;
    bus.Btarg = 0; bus.Jtarg = 0; bus.Zero = 0;
    bus.Overflow = 0; bus.Addr = 0; bus.Di = 0;
    bus.Rw = 0; bus.MemWr = 0; bus.Branch = 0;
    bus.Jump = 0; bus.MemtoReg = 0; bus.RegWr = 0;

    s = nop(); s.rst = 1; step(s); step(s);

    s = nop(); s.memwr = 1; s.addr = 32'h10;
    s.di = 32'hDEADBEEF; step(s);
    s = nop(); s.m2r = 1; s.regwr = 1; s.rw = 5'd7;
    s.addr = 32'h10; step(s);

    s = nop(); s.memwr = 1; s.regwr = 1; s.rw = 5'd3;
    s.addr = 32'h13; s.di = 32'h1234; step(s);
    s = nop(); s.m2r = 1; s.addr = 32'h10; step(s);

    s = nop(); s.rst = 1; step(s);
    s = nop(); s.ovf = 1; s.regwr = 1; s.rw = 5'd9;
    s.branch = 1; s.zero = 1; s.btarg = 30'h55;
    s.addr = 32'h40; step(s);
    s = nop(); s.m2r = 1; s.regwr = 1;
    s.addr = 32'h42; step(s);

    s = nop(); s.branch = 1; s.zero = 1;
    s.btarg = 30'h100; step(s);
    s = nop(); s.branch = 1; s.zero = 0;
    s.btarg = 30'h100; step(s);
    s = nop(); s.jump = 1; s.branch = 1; s.zero = 1;
    s.jtarg = 30'h200; s.btarg = 30'h100; step(s);

    s = nop(); s.rst = 1; step(s);
    s = nop(); s.memwr = 1; s.addr = 32'h20;
    s.di = 32'h77; step(s);
    s = nop(); s.rst = 1; s.memwr = 1;
    s.addr = 32'h20; s.di = 32'h5; step(s);
    s = nop(); s.m2r = 1; s.addr = 32'h20; step(s);

    s = nop(); s.memwr = 1; s.addr = 32'h1000;
    s.di = 32'hA5; step(s);
    s = nop(); s.m2r = 1; s.addr = 32'h0; step(s);

    for (int n = 0; n < 2000; n++) begin
      s = nop();
      s.rst    = ($urandom_range(0, 49) == 0);
      s.btarg  = 30'($urandom);
      s.jtarg  = 30'($urandom);
      s.zero   = 1'($urandom);
      s.ovf    = ($urandom_range(0, 9) == 0);
      s.addr   = $urandom & 32'h0000_00FC;
      if ($urandom_range(0, 7) == 0)
        s.addr = s.addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0)
        s.addr = s.addr | ($urandom & 32'hFFFF_F000);
      s.di     = $urandom;
      s.rw     = 5'($urandom);
      s.memwr  = ($urandom_range(0, 2) == 0);
      s.m2r    = !s.memwr && ($urandom_range(0, 1) == 0);
      s.branch = ($urandom_range(0, 3) == 0);
      s.jump   = ($urandom_range(0, 7) == 0);
      s.regwr  = 1'($urandom);
      step(s);
    end

    s = nop(); step(s);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, expected 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined CPU, sitting directly downstream of the EX/MEM pipeline register and upstream of write-back. It contains the word-addressed data memory and resolves branch/jump redirection for the fetch unit. It suppresses stores and register writes for faulting instructions, and holds the MEM/WB pipeline register. A sticky fault recorder captures the first misaligned access or arithmetic overflow for debug.

## Interface
- DEPTH, 1024: data memory size in 32-bit words; power of two.
- AW, 10: word-index width, log2(DEPTH).

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline registers.
- rst  in  1  synchronous, active-high reset, sampled on the falling edge.
- Btarg, Jtarg  in  30 each  branch and jump word targets from EX/MEM.
- Zero, Overflow  in  1 each  ALU flags from EX/MEM.
- Addr  in  32  ALU result, used as the memory byte address.
- Di  in  32  store data.
- Rw  in  5  destination register.
- MemWr, Branch, Jump, MemtoReg, RegWr  in  1 each  control signals.
- PCsrc  out  2  next-PC select: 00 sequential, 01 branch, 10 jump. Combinational.
- PCtarg  out  30  redirect target word address. Combinational.
- Flush  out  1  squash younger instructions in IF/ID/EX. Combinational.
- Do_out  out  32  load data in the MEM/WB register.
- ALUout_out  out  32  Addr passed through to MEM/WB.
- Rw_out  out  5  MEM/WB destination register.
- MemtoReg_out, RegWr_out  out  1 each  MEM/WB control signals.
- Fault  out  1  sticky fault flag.
- FaultCause  out  2  01 misaligned, 10 overflow.
- FaultAddr  out  32  Addr of the first faulting instruction.

## Operation
- Fault qualifiers:
  - mis = (MemWr | MemtoReg) & (Addr[1:0] != 0)
  - kill = mis | Overflow
- Redirect logic:
  - taken = Branch & Zero & ~Overflow
  - Jump has priority over branch: PCsrc = Jump ? 10 : taken ? 01 : 00
  - PCtarg = Jtarg when Jump, otherwise Btarg
  - Flush = PCsrc != 00
- Memory:
  - Word index = Addr[AW+1:2]; upper address bits are ignored (aliasing).
  - Write: mem[idx] <= Di when MemWr & ~kill & ~rst.
  - Read: Do_out <= mem[idx] every cycle, read-before-write. A store-then-load to the same word in consecutive cycles returns the new data.
- MEM/WB register, loaded every cycle:
  - ALUout_out <= Addr
  - Rw_out <= Rw
  - MemtoReg_out <= MemtoReg & ~kill
  - RegWr_out <= RegWr & ~kill
- Fault recorder:
  - When kill and Fault==0: set Fault, record FaultCause (mis takes precedence over Overflow when both are set), and FaultAddr <= Addr.
  - Later faults do not overwrite the recorded values. Only rst clears them.
- Reset values:
  - All MEM/WB outputs = 0.
  - Fault = 0, FaultCause = 00, FaultAddr = 0.
  - Memory contents are not reset.
  - During rst: no memory write; combinational outputs still follow their inputs.

## Timing
- Combinational redirect: PCsrc, PCtarg and Flush are valid in the same cycle the EX/MEM register presents the instruction.
- Load latency: load data appears on Do_out at the falling edge that ends the MEM cycle, the same edge as all other MEM/WB fields. The write-back stage sees it one cycle after MEM.
- Store commit: the store takes effect at the falling edge ending its MEM cycle. A load in the next cycle observes it.
- Reset mid-operation: rst asserted alongside a store blocks the write. The MEM/WB register holds the reset value for the following cycle.
- Back-to-back faults in consecutive cycles: only the first is recorded.

## Test plan
- Store then load: MemWr, Addr=0x0000_0010, Di=0xDEADBEEF; next cycle MemtoReg, Addr=0x10 -> Do_out=0xDEADBEEF and RegWr_out passes through.
- Misaligned store: MemWr, Addr=0x13, Di=0x1234 -> word 4 unchanged; Fault=1, FaultCause=01, FaultAddr=0x13; RegWr_out=0.
- Overflow kill, then second fault: Overflow=1, RegWr=1, Branch=1, Zero=1 -> RegWr_out=0, PCsrc=00, FaultCause=10. A misaligned load next cycle leaves FaultCause=10 and FaultAddr unchanged.
- Redirects:
  - Branch=1, Zero=1, Btarg=0x100 -> PCsrc=01, PCtarg=0x100, Flush=1.
  - Branch with Zero=0 -> PCsrc=00, Flush=0.
  - Jump=1 with Branch=1, Zero=1, Jtarg=0x200 -> PCsrc=10, PCtarg=0x200.
- Reset during store: rst=1, MemWr=1, Addr=0x20, Di=5 -> mem[8] unchanged, all MEM/WB outputs 0, Fault=0.
- Aliasing: store 0xA5 at Addr=0x1000 (DEPTH=1024) -> a load from Addr=0x0 returns 0xA5.
